// File: rtl/dpram_port_if.sv
// rtl/dpram_port_if.sv - request/response port of the pseudo dual-port RAM mux
interface dpram_port_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/dpram_port_mux.sv
// rtl/dpram_port_mux.sv - time-multiplexes ports A/B onto one single-port SRAM on the doubled clock
module dpram_port_mux #(
    parameter int AW              = 8,
    parameter int DW              = 16,
    parameter int RD_LAT          = 1,
    parameter int WORK_CONSERVING = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    dpram_port_if.slave   a,
    dpram_port_if.slave   b,
    output logic          slot,
    output logic          sram_ce,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
);

    // Stage 0 of the tag pipe lines up with the registered SRAM command; the
    // remaining RD_LAT+1 stages cover the SRAM latency plus the capture edge.
    localparam int   NTAG = RD_LAT + 2;
    localparam logic WC   = (WORK_CONSERVING != 0);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_rd_lat_check
        $error("dpram_port_mux: RD_LAT must be in 1..4");
    end

    typedef enum logic {
        SLOT_A = 1'b0,
        SLOT_B = 1'b1
    } slot_e;

    slot_e           slot_q;
    slot_e           slot_d;
    logic            a_rdy;
    logic            b_rdy;
    logic            a_acc;
    logic            b_acc;
    logic            rd_acc;
    logic [NTAG-1:0] tag_v;
    logic [NTAG-1:0] tag_b;
    logic            a_rv_q;
    logic            b_rv_q;
    logic [DW-1:0]   a_rd_q;
    logic [DW-1:0]   b_rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT_A;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Slot owner always wins; the other port may borrow only an idle slot.
    always_comb begin
        slot_d = (slot_q == SLOT_A) ? SLOT_B : SLOT_A;
        a_rdy  = 1'b0;
        b_rdy  = 1'b0;
        if (rst_n) begin
            if (slot_q == SLOT_A) begin
                a_rdy = 1'b1;
                b_rdy = WC && !a.req;
            end else begin
                b_rdy = 1'b1;
                a_rdy = WC && !b.req;
            end
        end
    end

    assign a_acc  = a.req && a_rdy;
    assign b_acc  = b.req && b_rdy;
    assign rd_acc = (a_acc && !a.we) || (b_acc && !b.we);
    assign slot   = (slot_q == SLOT_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            sram_ce <= a_acc || b_acc;
            if (a_acc) begin
                sram_we    <= a.we;
                sram_addr  <= a.addr;
                sram_wdata <= a.wdata;
            end else if (b_acc) begin
                sram_we    <= b.we;
                sram_addr  <= b.addr;
                sram_wdata <= b.wdata;
            end else begin
                sram_we <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_b  <= '0;
            a_rv_q <= 1'b0;
            b_rv_q <= 1'b0;
            a_rd_q <= '0;
            b_rd_q <= '0;
        end else begin
            tag_v  <= {tag_v[NTAG-2:0], rd_acc};
            tag_b  <= {tag_b[NTAG-2:0], b_acc};
            a_rv_q <= tag_v[NTAG-1] && !tag_b[NTAG-1];
            b_rv_q <= tag_v[NTAG-1] && tag_b[NTAG-1];
            if (tag_v[NTAG-1] && !tag_b[NTAG-1]) begin
                a_rd_q <= sram_rdata;
            end
            if (tag_v[NTAG-1] && tag_b[NTAG-1]) begin
                b_rd_q <= sram_rdata;
            end
        end
    end

    assign a.ready  = a_rdy;
    assign b.ready  = b_rdy;
    assign a.rvalid = a_rv_q;
    assign b.rvalid = b_rv_q;
    assign a.rdata  = a_rd_q;
    assign b.rdata  = b_rd_q;

endmodule
